xor_gate_bist: RTL and testbench
================================

# xor_gate_bist

Built-in self-test controller for the `xor_gate` datapath cell. On a start pulse it sequences the cell's two inputs through all four combinations in the order 00, 01, 10, 11. Each vector is held for a programmable dwell time. The controller then samples the cell output, compares it against the expected XOR value, and reports pass/fail, the error count and the first failing vector. It sits beside the `xor_gate` instance and drives its `a` and `b` inputs directly.

## Interface
- `DWELL`, default 4: cycles each vector is driven before the output is sampled; legal range 1..255.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to run the test; accepted only in IDLE.
- `c_in`  in  1  output of the `xor_gate` under test.
- `a_out`  out  1  drives the `a` input of the `xor_gate` instance; registered.
- `b_out`  out  1  drives the `b` input of the `xor_gate` instance; registered.
- `busy`  out  1  high while a test is in progress (APPLY/SAMPLE).
- `done`  out  1  one-cycle pulse when a test completes.
- `pass`  out  1  result of the last completed test; held until the next accepted start.
- `err_count`  out  3  number of mismatching vectors in the current or last test, 0..4.
- `fail_vec`  out  2  first mismatching vector as {a,b}; meaningful only when `pass`=0 after `done`.

## Operation
- Internal state: a 2-bit vector index `vec`, a dwell counter wide enough for `DWELL`-1, and a four-state FSM.
- IDLE:
  - `a_out`=`b_out`=0 and `busy`=0.
  - `start`=1 moves to APPLY and clears `vec`, the dwell counter, `err_count`, `fail_vec` and `pass`.
- APPLY:
  - `a_out`=`vec[1]` and `b_out`=`vec[0]`; `busy`=1.
  - The dwell counter increments each cycle.
  - When the counter equals `DWELL`-1, the FSM moves to SAMPLE.
- SAMPLE:
  - Outputs keep driving `vec`; `busy`=1.
  - Compare `c_in` with `vec[1]^vec[0]`.
  - On mismatch, `err_count` increments. If `err_count` was 0, `fail_vec` is set to `vec`.
  - If `vec`=3, the FSM moves to DONE.
  - Otherwise `vec` increments, the dwell counter clears, and the FSM returns to APPLY.
- DONE:
  - `done`=1 for exactly one cycle; `busy`=0; `a_out`=`b_out`=0.
  - `pass` is set to (`err_count`==0) when DONE is entered.
  - Next state is IDLE.
- `start` is ignored in APPLY, SAMPLE and DONE. It causes no restart and is not queued.
- `err_count` cannot overflow, because the maximum value is 4.

## Timing
- Reset values (applied immediately on `rst` assertion, without waiting for a clock): FSM=IDLE, `a_out`=0, `b_out`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=00.
- If reset is asserted mid-test, the run is aborted with no `done` pulse. A `start` after `rst` is released runs a full, fresh test.
- Let `start` be sampled high at edge E0 while in IDLE.
  - `busy`, and the first vector on `a_out`/`b_out`, become visible after E0.
  - Each vector is held for `DWELL`+1 cycles (`DWELL` cycles in APPLY plus 1 in SAMPLE).
  - `c_in` is sampled at the final edge of each vector, at E0+k(`DWELL`+1) for k=1..4.
  - `busy` stays high for 4(`DWELL`+1) cycles.
  - `done` is high during the cycle after edge E0+4(`DWELL`+1).
- `pass`, `err_count` and `fail_vec` are valid and stable from the `done` cycle until the next accepted `start`.
- The `xor_gate` is combinational. `DWELL`≥1 guarantees at least one full cycle of settling before sampling.

## Test plan
- Golden `xor_gate`, `DWELL`=4, one-cycle `start`:
  - `a_out`/`b_out` step 00, 01, 10, 11, each held 5 cycles.
  - `busy` is high for 20 cycles and `done` pulses once.
  - Result: `pass`=1, `err_count`=0.
- Faulty model with output stuck at 0, `DWELL`=4 -> `err_count`=2, `fail_vec`=01, `pass`=0.
- XNOR substituted for the cell -> `err_count`=4, `fail_vec`=00, `pass`=0.
- `start` pulsed again during vector 2, and again in the DONE cycle:
  - No restart occurs and no second `done` appears.
  - A later `start` in IDLE runs a clean test that clears `err_count`.
- `rst` asserted mid-APPLY of vector 10:
  - All outputs return to their reset values before the next clock edge, with no `done` pulse.
  - After release, a fresh `start` gives `pass`=1 on the golden model.
- `DWELL`=1 boundary -> each vector held 2 cycles, `busy` high for 8 cycles, `done` in the 9th cycle after E0, `pass`=1.

Source files
------------

// File: rtl/xor_gate_bist.sv
// xor_gate_bist: built-in self-test controller for an xor_gate cell.
// Steps the cell inputs through 00, 01, 10, 11. Each vector is held DWELL cycles
// in APPLY plus one cycle in SAMPLE. The controller compares the cell output with
// the expected XOR value at the end of each vector and reports the result.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      one-cycle run request, accepted only in IDLE
//   c_in       output of the xor_gate under test
//   a_out      drives xor_gate input a (registered)
//   b_out      drives xor_gate input b (registered)
//   busy       high while a test is in progress (APPLY/SAMPLE)
//   done       one-cycle pulse when a test completes
//   pass       result of the last completed test, held until the next start
//   err_count  number of mismatching vectors in the current/last test (0..4)
//   fail_vec   first mismatching vector {a,b}; valid when pass=0 after done
module xor_gate_bist #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       c_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] fail_vec
);

    // The counter only needs to reach DWELL-1, so at least one bit is kept.
    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned ERR_W = 3;
    localparam int unsigned VEC_W = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t             state;
    logic [VEC_W-1:0]   vec;
    logic [CNT_W-1:0]   cnt;
    logic [VEC_W-1:0]   vec_next_c;
    logic               mismatch_c;

    // Cell output compared against the XOR of the vector currently driven.
    assign mismatch_c = c_in != (vec[1] ^ vec[0]);
    assign vec_next_c = vec + VEC_W'(1);

    // Controller FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            vec       <= '0;
            cnt       <= '0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    a_out <= 1'b0;
                    b_out <= 1'b0;
                    busy  <= 1'b0;
                    if (start) begin
                        state     <= S_APPLY;
                        vec       <= '0;
                        cnt       <= '0;
                        err_count <= '0;
                        fail_vec  <= '0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_APPLY: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DWELL - 1)) begin
                        state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if (mismatch_c) begin
                        err_count <= err_count + ERR_W'(1);
                        if (err_count == '0) begin
                            fail_vec <= vec;
                        end
                    end
                    if (vec == VEC_W'(3)) begin
                        // Final vector: pass must include this last comparison.
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        a_out <= 1'b0;
                        b_out <= 1'b0;
                        pass  <= (err_count == '0) && !mismatch_c;
                    end else begin
                        state <= S_APPLY;
                        vec   <= vec_next_c;
                        cnt   <= '0;
                        a_out <= vec_next_c[1];
                        b_out <= vec_next_c[0];
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xor_gate_bist.sv
// Testbench for xor_gate_bist: two instances (DWELL=4 and DWELL=1), each beside a
// faultable xor cell model. The model flips the cell output on the vectors set in
// a 4-bit fault mask. The expected sequence and results come from the mask alone.
module tb_xor_gate_bist;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start4 = 1'b0, start1 = 1'b0;
    logic       c4, c1;
    logic       a4, b4, busy4, done4, pass4;
    logic       a1, b1, busy1, done1, pass1;
    logic [2:0] err4, err1;
    logic [1:0] fail4, fail1;
    logic [3:0] mask4 = 4'h0, mask1 = 4'h0;

    int checks = 0;
    int errors = 0;
    int sel = 0;

    always #5 clk = ~clk;

    // Faultable xor cells: bit {a,b} of the mask inverts the output for that vector.
    assign c4 = (a4 ^ b4) ^ mask4[{a4, b4}];
    assign c1 = (a1 ^ b1) ^ mask1[{a1, b1}];

    xor_gate_bist #(.DWELL(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .c_in(c4),
        .a_out(a4), .b_out(b4), .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err4), .fail_vec(fail4)
    );

    xor_gate_bist #(.DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .c_in(c1),
        .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fail1)
    );

    // Outputs of the instance currently under test.
    logic       a_s, b_s, busy_s, done_s, pass_s;
    logic [2:0] err_s;
    logic [1:0] fail_s;
    always_comb begin
        if (sel == 0) begin
            a_s = a4; b_s = b4; busy_s = busy4; done_s = done4; pass_s = pass4;
            err_s = err4; fail_s = fail4;
        end else begin
            a_s = a1; b_s = b1; busy_s = busy1; done_s = done1; pass_s = pass1;
            err_s = err1; fail_s = fail1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel == 0) start4 = v; else start1 = v;
    endtask

    // Number of faulty vectors among the first n vectors.
    function automatic int faults_in(input logic [3:0] m, input int n);
        int c = 0;
        for (int k = 0; k < n; k++) c += int'(m[k]);
        return c;
    endfunction

    function automatic int first_fault(input logic [3:0] m);
        for (int k = 0; k < 4; k++) if (m[k]) return k;
        return 0;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_a"}, 32'(a_s), 0);
        check({tag, "_b"}, 32'(b_s), 0);
        check({tag, "_busy"}, 32'(busy_s), 0);
        check({tag, "_done"}, 32'(done_s), 0);
    endtask

    task automatic check_result(input string tag, input logic [3:0] m);
        int nf = faults_in(m, 4);
        check({tag, "_pass"}, 32'(pass_s), (nf == 0) ? 1 : 0);
        check({tag, "_err"}, 32'(err_s), 32'(nf));
        if (nf != 0) check({tag, "_fail_vec"}, 32'(fail_s), 32'(first_fault(m)));
    endtask

    // One full run on instance s; poke re-pulses start during vector 2 and in DONE.
    task automatic run_test(input int s, input logic [3:0] m, input int dw, input bit poke);
        int per = dw + 1;
        sel = s;
        if (s == 0) mask4 = m; else mask1 = m;
        @(negedge clk);
        set_start(1'b1);
        for (int i = 0; i < 4 * per; i++) begin
            @(negedge clk);
            if (i == 0) set_start(1'b0);
            check("run_a", 32'(a_s), 32'((i / per) >> 1));
            check("run_b", 32'(b_s), 32'((i / per) & 1));
            check("run_busy", 32'(busy_s), 1);
            check("run_done", 32'(done_s), 0);
            check("run_pass", 32'(pass_s), 0);
            check("run_err", 32'(err_s), 32'(faults_in(m, i / per)));
            if (poke && i == 2 * per + 1) set_start(1'b1);
            if (poke && i == 2 * per + 2) set_start(1'b0);
        end
        @(negedge clk);
        check("done_pulse", 32'(done_s), 1);
        check("done_busy", 32'(busy_s), 0);
        check("done_a", 32'(a_s), 0);
        check("done_b", 32'(b_s), 0);
        check_result("done", m);
        if (poke) set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        check_idle("after");
        check_result("held", m);
        repeat (3) begin
            @(negedge clk);
            check_idle("quiet");
        end
        check_result("held_late", m);
    endtask

    initial begin
        #2;
        sel = 0;
        check("rst_a", 32'(a4), 0);
        check("rst_busy", 32'(busy4), 0);
        check("rst_done", 32'(done4), 0);
        check("rst_pass", 32'(pass4), 0);
        check("rst_err", 32'(err4), 0);
        check("rst_fail", 32'(fail4), 0);
        check("rst1_busy", 32'(busy1), 0);
        @(negedge clk);
        rst = 1'b0;

        run_test(0, 4'b0000, 4, 1'b0);   // golden
        run_test(0, 4'b0110, 4, 1'b0);   // stuck-at-0
        run_test(0, 4'b1111, 4, 1'b0);   // xnor substitute
        run_test(0, 4'b1111, 4, 1'b1);   // extra starts ignored
        run_test(0, 4'b0000, 4, 1'b0);   // clean rerun clears err_count
        run_test(1, 4'b0000, 1, 1'b0);   // DWELL=1 boundary
        run_test(1, 4'b1000, 1, 1'b1);
        for (int r = 0; r < 6; r++) begin
            run_test(0, 4'($urandom_range(15)), 4, 1'($urandom_range(1)));
            run_test(1, 4'($urandom_range(15)), 1, 1'($urandom_range(1)));
        end

        // Reset during APPLY of vector 10 with two errors already recorded.
        sel = 0;
        mask4 = 4'b0011;
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (2 * 5) @(negedge clk);
        check("pre_rst_err", 32'(err4), 2);
        check("pre_rst_vec", 32'({a4, b4}), 2);
        rst = 1'b1;
        #1;
        check("mid_rst_a", 32'(a4), 0);
        check("mid_rst_busy", 32'(busy4), 0);
        check("mid_rst_done", 32'(done4), 0);
        check("mid_rst_pass", 32'(pass4), 0);
        check("mid_rst_err", 32'(err4), 0);
        check("mid_rst_fail", 32'(fail4), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            check_idle("post_rst");
        end
        run_test(0, 4'b0000, 4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
